// File: rtl/rsp_pkt_pkg.sv
// rsp_pkt_pkg: shared constants, types and packet builders for the
// response arbiter.
//   - SOP/EOP markers and packet type codes
//   - bit offsets of every packet field
//   - source enum (WR = B channel, RD = R channel) and arbiter lock state
//   - make_b_pkt / make_r_pkt assemble the 128-bit FIFO words
package rsp_pkt_pkg;

  localparam logic [7:0] SOP   = 8'hAA;
  localparam logic [7:0] EOP   = 8'h53;
  localparam logic [7:0] PKT_B = 8'h01;
  localparam logic [7:0] PKT_R = 8'h02;

  localparam int OFS_SOP    = 120;
  localparam int OFS_TYPE   = 112;
  localparam int OFS_ID     = 104;
  localparam int OFS_RESP   = 96;
  localparam int OFS_B_EOP  = 88;
  localparam int OFS_R_DATA = 64;
  localparam int OFS_R_LAST = 56;
  localparam int OFS_R_EOP  = 48;

  typedef enum logic {WR, RD} src_e;

  typedef enum logic {ARB_OPEN, ARB_BURST} arb_st_e;

  function automatic logic [127:0] make_b_pkt(input logic [7:0] id,
                                              input logic [3:0] resp);
    logic [127:0] pkt;
    pkt = '0;
    pkt[OFS_SOP +: 8]   = SOP;
    pkt[OFS_TYPE +: 8]  = PKT_B;
    pkt[OFS_ID +: 8]    = id;
    pkt[OFS_RESP +: 8]  = {4'h0, resp};
    pkt[OFS_B_EOP +: 8] = EOP;
    return pkt;
  endfunction

  function automatic logic [127:0] make_r_pkt(input logic [7:0]  id,
                                              input logic [3:0]  resp,
                                              input logic [31:0] data,
                                              input logic        last);
    logic [127:0] pkt;
    pkt = '0;
    pkt[OFS_SOP +: 8]     = SOP;
    pkt[OFS_TYPE +: 8]    = PKT_R;
    pkt[OFS_ID +: 8]      = id;
    pkt[OFS_RESP +: 8]    = {4'h0, resp};
    pkt[OFS_R_DATA +: 32] = data;
    pkt[OFS_R_LAST +: 8]  = {7'b0, last};
    pkt[OFS_R_EOP +: 8]   = EOP;
    return pkt;
  endfunction

endpackage

// File: rtl/rsp_arbiter_if.sv
// rsp_arbiter_if: B/R response inputs, read-FIFO write port and status.
//   slave  : arbiter side (takes beats, drives FIFO port and status)
//   master : response source / FIFO side
interface rsp_arbiter_if #(
  parameter int data_wid = 32,
  parameter int id_wid   = 4
);
  logic                wr_rsp_en;
  logic [id_wid-1:0]   bid;
  logic [3:0]          bresp;
  logic                wr_rsp_ready;
  logic                rd_rsp_en;
  logic [id_wid-1:0]   rid;
  logic [data_wid-1:0] rdata;
  logic [3:0]          rresp;
  logic                rlast;
  logic                rd_rsp_ready;
  logic                fifo_full;
  logic                write_enable;
  logic [127:0]        fifo_wdata;
  logic                err_ovf;
  logic [15:0]         wr_pkt_cnt;
  logic [15:0]         rd_pkt_cnt;

  modport slave (
    input  wr_rsp_en, bid, bresp, rd_rsp_en, rid, rdata, rresp, rlast, fifo_full,
    output wr_rsp_ready, rd_rsp_ready, write_enable, fifo_wdata, err_ovf,
           wr_pkt_cnt, rd_pkt_cnt
  );

  modport master (
    output wr_rsp_en, bid, bresp, rd_rsp_en, rid, rdata, rresp, rlast, fifo_full,
    input  wr_rsp_ready, rd_rsp_ready, write_enable, fifo_wdata, err_ovf,
           wr_pkt_cnt, rd_pkt_cnt
  );
endinterface

// File: rtl/rsp_queue.sv
// rsp_queue: small synchronous FIFO.
//   push_i/din_i : write when not full (full is the pre-edge state)
//   pop_i        : drop head when not empty
//   full_o/empty_o/head_o : registered-state status and head entry
module rsp_queue #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [width-1:0] head_o
);
  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/rsp_arbiter.sv
// rsp_arbiter: queues AXI B and R beats and packetizes them onto the
// single read-FIFO write port, round-robin between sources, keeping R
// bursts contiguous.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rsp_arbiter_if.slave (beat inputs, FIFO port, status)
//
// state     | meaning
// ----------|------------------------------------------------------
// ARB_OPEN  | round-robin between B and R queues (rr_q breaks ties)
// ARB_BURST | mid R burst: only the R queue may be granted
module rsp_arbiter
  import rsp_pkt_pkg::*;
#(
  parameter int data_wid = 32,
  parameter int id_wid   = 4,
  parameter int q_depth  = 4
) (
  input logic           clk,
  input logic           rst,
  rsp_arbiter_if.slave  bus
);
  localparam int BW = id_wid + 4;
  localparam int RW = id_wid + 4 + data_wid + 1;

  logic          b_full, b_empty, b_pop;
  logic          r_full, r_empty, r_pop;
  logic [BW-1:0] b_head;
  logic [RW-1:0] r_head;

  arb_st_e       arb_q, arb_d;
  src_e          rr_q, rr_d;
  logic          err_ovf_q, err_ovf_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic          grant_valid, we;
  src_e          grant_src;
  logic [127:0]  wdata;

  rsp_queue #(.width(BW), .depth(q_depth)) u_b_q (
    .clk(clk), .rst(rst), .push_i(bus.wr_rsp_en), .pop_i(b_pop),
    .din_i({bus.bid, bus.bresp}),
    .full_o(b_full), .empty_o(b_empty), .head_o(b_head)
  );

  rsp_queue #(.width(RW), .depth(q_depth)) u_r_q (
    .clk(clk), .rst(rst), .push_i(bus.rd_rsp_en), .pop_i(r_pop),
    .din_i({bus.rid, bus.rresp, bus.rdata, bus.rlast}),
    .full_o(r_full), .empty_o(r_empty), .head_o(r_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q     <= ARB_OPEN;
      rr_q      <= WR;
      err_ovf_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      arb_q     <= arb_d;
      rr_q      <= rr_d;
      err_ovf_q <= err_ovf_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  always_comb begin
    arb_d       = arb_q;
    rr_d        = rr_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    grant_valid = 1'b0;
    grant_src   = rr_q;
    // Drop detection uses pre-edge full, so a same-cycle pop does not help.
    err_ovf_d   = err_ovf_q | (bus.wr_rsp_en & b_full) | (bus.rd_rsp_en & r_full);

    unique case (arb_q)
      ARB_BURST: begin
        grant_valid = ~r_empty;
        grant_src   = RD;
      end
      ARB_OPEN: begin
        if (!b_empty && !r_empty) begin
          grant_valid = 1'b1;
          grant_src   = rr_q;
        end else if (!b_empty) begin
          grant_valid = 1'b1;
          grant_src   = WR;
        end else if (!r_empty) begin
          grant_valid = 1'b1;
          grant_src   = RD;
        end
      end
    endcase

    we    = grant_valid & ~bus.fifo_full;
    b_pop = we & (grant_src == WR);
    r_pop = we & (grant_src == RD);

    if (we) begin
      rr_d = (grant_src == WR) ? RD : WR;
      if (grant_src == WR) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 16'd1;
        arb_d    = r_head[0] ? ARB_OPEN : ARB_BURST;
      end
    end
  end

  always_comb begin
    wdata = '0;
    if (we) begin
      if (grant_src == WR)
        wdata = make_b_pkt(8'(b_head[BW-1 -: id_wid]), b_head[3:0]);
      else
        wdata = make_r_pkt(8'(r_head[RW-1 -: id_wid]),
                           r_head[RW-id_wid-1 -: 4],
                           r_head[data_wid:1],
                           r_head[0]);
    end
  end

  assign bus.write_enable = we;
  assign bus.fifo_wdata   = wdata;
  assign bus.wr_rsp_ready = ~b_full;
  assign bus.rd_rsp_ready = ~r_full;
  assign bus.err_ovf      = err_ovf_q;
  assign bus.wr_pkt_cnt   = wr_cnt_q;
  assign bus.rd_pkt_cnt   = rd_cnt_q;
endmodule
